// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/subtract datapath between two requesters.
// Each operation is issued in IDLE, executes for one cycle in EXEC, and completes into res.
module addsub_arbiter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res,
    output logic         busy,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic         dp_sub,
    input  logic [W-1:0] dp_res
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_grant0;
    logic         w_grant1;
    logic         r_last;
    logic         r_owner;
    logic         r_gnt0;
    logic         r_gnt1;
    logic         r_done0;
    logic         r_done1;
    logic [W-1:0] r_res;
    logic [W-1:0] r_dp_a;
    logic [W-1:0] r_dp_b;
    logic         r_dp_sub;

    // r_last = 1 means channel 1 was served last, so channel 0 wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant0 = req0 && (!req1 || r_last);
                w_grant1 = req1 && !w_grant0;
                if (w_grant0 || w_grant1)
                    w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_res    <= '0;
            r_dp_a   <= '0;
            r_dp_b   <= '0;
            r_dp_sub <= 1'b0;
        end else begin
            r_gnt0  <= w_grant0;
            r_gnt1  <= w_grant1;
            r_done0 <= (r_state == EXEC) && !r_owner;
            r_done1 <= (r_state == EXEC) && r_owner;
            if (w_grant0 || w_grant1) begin
                r_dp_a   <= w_grant1 ? a1  : a0;
                r_dp_b   <= w_grant1 ? b1  : b0;
                r_dp_sub <= w_grant1 ? op1 : op0;
                r_owner  <= w_grant1;
                r_last   <= w_grant1;
            end
            if (r_state == EXEC)
                r_res <= dp_res;
        end
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign res    = r_res;
    assign busy   = (r_state == EXEC);
    assign dp_a   = r_dp_a;
    assign dp_b   = r_dp_b;
    assign dp_sub = r_dp_sub;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed vector table, reset/fairness sequences and
// randomized requesters checked against an operation-level reference model.
module tb_addsub_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  t_req;
    logic [1:0]  t_op;
    logic [31:0] t_a [2];
    logic [31:0] t_b [2];
    logic        gnt0, gnt1, done0, done1, busy, dp_sub;
    logic [31:0] res, dp_a, dp_b, dp_res;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign dp_res = dp_sub ? dp_a - dp_b : dp_a + dp_b;

    addsub_arbiter #(.W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(t_req[0]), .req1(t_req[1]), .op0(t_op[0]), .op1(t_op[1]),
        .a0(t_a[0]), .b0(t_b[0]), .a1(t_a[1]), .b1(t_b[1]),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .busy(busy), .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
        .dp_res(dp_res)
    );

    typedef struct {
        logic        r0, r1, o0, o1;
        logic [31:0] a0, b0, a1, b1;
        logic        g0, g1, d0, d1, bz;
        logic [31:0] rs;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic g0, input logic g1, input logic d0,
                       input logic d1, input logic bz, input logic [31:0] rs);
        n_vec++;
        if ({gnt0, gnt1, done0, done1, busy, res} !== {g0, g1, d0, d1, bz, rs}) begin
            n_err++;
            $display("FAIL %s: got gnt=%b%b done=%b%b busy=%b res=%h, want gnt=%b%b done=%b%b busy=%b res=%h",
                     nm, gnt0, gnt1, done0, done1, busy, res, g0, g1, d0, d1, bz, rs);
        end
    endtask

    task automatic chk_dp(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                          input logic es);
        n_vec++;
        if ({dp_a, dp_b, dp_sub} !== {ea, eb, es}) begin
            n_err++;
            $display("FAIL %s: got dp_a=%h dp_b=%h dp_sub=%b, want dp_a=%h dp_b=%h dp_sub=%b",
                     nm, dp_a, dp_b, dp_sub, ea, eb, es);
        end
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic o0, input logic o1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1);
        t_req = {r1, r0};
        t_op  = {o1, o0};
        t_a[0] = a0; t_b[0] = b0; t_a[1] = a1; t_b[1] = b1;
    endtask

    task automatic do_reset();
        t_req = 2'b00;
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // reference model state (operation level)
    logic        m_inflight, m_owner, m_last, m_dps;
    logic [31:0] m_pend, m_res, m_dpa, m_dpb;

    initial begin
        logic        e_g [2];
        logic        e_d [2];
        logic        e_bz;
        int          w;
        logic [31:0] fres [2];
        logic [31:0] cur_res;

        RST_N = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        //            r0 r1 o0 o1  a0   b0  a1  b1   g0 g1 d0 d1 bz  res
        tbl[0]  = '{1, 0, 0, 0, 5,   3,  0,  0,  1, 0, 0, 0, 1, 32'h0};
        tbl[1]  = '{0, 0, 0, 0, 100, 3,  0,  0,  0, 0, 1, 0, 0, 32'd8};
        tbl[2]  = '{0, 1, 0, 1, 100, 3,  3,  5,  0, 1, 0, 0, 1, 32'd8};
        tbl[3]  = '{0, 0, 0, 1, 100, 3,  3,  5,  0, 0, 0, 1, 0, 32'hFFFFFFFE};
        tbl[4]  = '{0, 0, 0, 1, 100, 3,  3,  5,  0, 0, 0, 0, 0, 32'hFFFFFFFE};
        tbl[5]  = '{1, 1, 0, 1, 1,   1,  9,  4,  1, 0, 0, 0, 1, 32'hFFFFFFFE};
        tbl[6]  = '{0, 1, 0, 1, 1,   1,  9,  4,  0, 0, 1, 0, 0, 32'd2};
        tbl[7]  = '{0, 1, 0, 1, 1,   1,  9,  4,  0, 1, 0, 0, 1, 32'd2};
        tbl[8]  = '{0, 0, 0, 1, 1,   1,  9,  4,  0, 0, 0, 1, 0, 32'd5};
        tbl[9]  = '{1, 1, 0, 1, 1,   1,  9,  4,  1, 0, 0, 0, 1, 32'd5};
        tbl[10] = '{1, 1, 0, 1, 1,   1,  9,  4,  0, 0, 1, 0, 0, 32'd2};
        tbl[11] = '{1, 1, 0, 1, 1,   1,  9,  4,  0, 1, 0, 0, 1, 32'd2};
        tbl[12] = '{0, 0, 0, 1, 1,   1,  9,  4,  0, 0, 0, 1, 0, 32'd5};

        #12;
        chk("reset_outputs", 0, 0, 0, 0, 0, 32'h0);
        chk_dp("reset_dp", 32'h0, 32'h0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].r0, tbl[i].r1, tbl[i].o0, tbl[i].o1,
                   tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
            tick();
            chk($sformatf("table[%0d]", i), tbl[i].g0, tbl[i].g1, tbl[i].d0,
                tbl[i].d1, tbl[i].bz, tbl[i].rs);
        end

        // Reset during EXEC: abandon the op, then the tie must go to channel 0.
        set_in(1, 0, 0, 0, 5, 3, 0, 0);
        tick();
        chk("midop_grant", 1, 0, 0, 0, 1, 32'd5);
        t_req = 2'b00;
        #1;
        RST_N = 1'b0;
        #1;
        chk("midop_async_clear", 0, 0, 0, 0, 0, 32'h0);
        chk_dp("midop_dp_clear", 32'h0, 32'h0, 1'b0);
        tick();
        chk("midop_no_done", 0, 0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        set_in(1, 1, 0, 1, 1, 1, 9, 4);
        tick();
        chk("tie_after_reset_gnt0", 1, 0, 0, 0, 1, 32'h0);
        t_req = 2'b10;
        tick();
        chk("tie_after_reset_done0", 0, 0, 1, 0, 0, 32'd2);
        tick();
        chk("tie_after_reset_gnt1", 0, 1, 0, 0, 1, 32'd2);
        t_req = 2'b00;
        tick();
        chk("tie_after_reset_done1", 0, 0, 0, 1, 0, 32'd5);

        // Randomized requesters against the reference model.
        do_reset();
        m_inflight = 0; m_owner = 0; m_last = 1; m_res = 0;
        m_dpa = 0; m_dpb = 0; m_dps = 0; m_pend = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                logic g;
                g = (k == 0) ? gnt0 : gnt1;
                if (!t_req[k] || g) begin
                    if ($urandom_range(1, 0) == 1) begin
                        t_req[k] = 1'b1;
                        t_op[k]  = 1'($urandom_range(1, 0));
                        t_a[k]   = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFF : $urandom;
                        t_b[k]   = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFF : $urandom;
                    end else begin
                        t_req[k] = 1'b0;
                    end
                end
            end
            e_g[0] = 0; e_g[1] = 0; e_d[0] = 0; e_d[1] = 0; e_bz = 0;
            if (m_inflight) begin
                e_d[m_owner] = 1;
                m_res = m_pend;
                m_inflight = 0;
            end else if (t_req != 2'b00) begin
                if (t_req == 2'b11) w = m_last ? 0 : 1;
                else                w = t_req[1] ? 1 : 0;
                e_g[w] = 1;
                e_bz = 1;
                m_pend = t_op[w] ? t_a[w] - t_b[w] : t_a[w] + t_b[w];
                m_dpa = t_a[w]; m_dpb = t_b[w]; m_dps = t_op[w];
                m_owner = w[0]; m_last = w[0]; m_inflight = 1;
            end
            tick();
            chk($sformatf("random[%0d]", c), e_g[0], e_g[1], e_d[0], e_d[1], e_bz, m_res);
            chk_dp($sformatf("random_dp[%0d]", c), m_dpa, m_dpb, m_dps);
        end

        // Fairness: both held for 12 cycles gives alternating grants 0,1,0,1,0,1.
        do_reset();
        set_in(1, 1, 0, 1, 10, 1, 10, 1);
        fres[0] = 32'd11;
        fres[1] = 32'd9;
        cur_res = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("fair_gnt[%0d]", i), (i / 2) % 2 == 0, (i / 2) % 2 == 1,
                    0, 0, 1, cur_res);
            end else begin
                cur_res = fres[((i - 1) / 2) % 2];
                chk($sformatf("fair_done[%0d]", i), 0, 0, ((i - 1) / 2) % 2 == 0,
                    ((i - 1) / 2) % 2 == 1, 0, cur_res);
            end
        end
        t_req = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one combinational 32-bit adder/subtractor datapath between two requesters. It uses round-robin arbitration and a registered operand/result pipeline. It sits between the switch/console front ends and the shared adder/subtractor, and sequences each operation as issue → capture → done. Results are returned in a result register that downstream logic, such as the 7-segment display mux, can read.

## Interface
- W, 32, operand/result width; must match the shared datapath width.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset: one clock; reset is asynchronous and active-low.
- req0 / req1  in  1  request from channel 0 / 1; level, held until the matching gnt.
- op0 / op1  in  1  operation for channel 0 / 1: 0 = add, 1 = subtract (a − b).
- a0, b0 / a1, b1  in  W  operands for channel 0 / 1; must be stable while req is high and not yet granted.
- gnt0 / gnt1  out  1  one-cycle pulse; the channel's operands were captured and it may change them.
- done0 / done1  out  1  one-cycle pulse; `res` holds that channel's result.
- res  out  W  registered result of the most recently completed operation; held until the next completion.
- busy  out  1  high while an operation is in flight (state EXEC).
- dp_a, dp_b  out  W  registered operands to the shared datapath.
- dp_sub  out  1  registered mode to the shared datapath: 0 = add, 1 = subtract.
- dp_res  in  W  combinational datapath result: dp_a ± dp_b modulo 2^W.

## Operation
- FSM has two states:
  - IDLE: arbitrates; busy = 0.
  - EXEC: an operation is in flight; busy = 1.
- IDLE, no req asserted → stay in IDLE; dp_* hold their last values.
- IDLE, exactly one req asserted → grant that channel.
- IDLE, both req asserted → grant the channel that was not served last (`last` pointer).
- On a grant (edge into EXEC):
  - dp_a ← a_k, dp_b ← b_k, dp_sub ← op_k.
  - owner ← k, last ← k.
  - gnt_k = 1 for exactly that cycle.
- EXEC (edge back to IDLE):
  - res ← dp_res.
  - done_owner = 1 for exactly the following cycle.
  - State returns to IDLE.
- req is sampled only in IDLE; req changes during EXEC are ignored.
- A requester still asserting req in the IDLE cycle after gnt is treated as a new request.
- Arithmetic:
  - No carry or overflow flag is produced.
  - Subtraction wraps modulo 2^W, e.g. 3 − 5 → 0xFFFFFFFE.
  - res is passed through unaltered from dp_res.
- gnt0/gnt1 are mutually exclusive, as are done0/done1.

## Timing
- Reset (RST_N = 0, asynchronous):
  - state = IDLE, last = 1 (channel 0 wins the first tie).
  - gnt0 = gnt1 = done0 = done1 = busy = 0.
  - res = 0, dp_a = dp_b = 0, dp_sub = 0.
- Latency, with req_k seen high in IDLE cycle t:
  - gnt_k and busy high in cycle t+1.
  - done_k high and res valid in cycle t+2.
- Throughput: one operation per 2 cycles. The next grant can occur at t+3 because cycle t+2 is IDLE and arbitrates.
- Back-to-back with both req held high: grants alternate 0,1,0,1… at cycles t+1, t+3, t+5, …
- Reset asserted during EXEC:
  - The operation is abandoned; no done pulse is produced.
  - res returns to 0.
  - After release, arbitration restarts with channel 0 priority.
- Release of RST_N is synchronised externally. The block takes no action until the first rising CLK edge after release.

## Test plan
Bench models dp_res = dp_sub ? dp_a − dp_b : dp_a + dp_b (combinational), with W = 32.
- Single add: req0 = 1, op0 = 0, a0 = 5, b0 = 3 in cycle t → gnt0 at t+1, done0 at t+2, res = 8; gnt1/done1 stay 0.
- Subtract wrap: req1 = 1, op1 = 1, a1 = 3, b1 = 5 → done1 at t+2, res = 0xFFFFFFFE.
- Tie after reset: req0 = req1 = 1 with a0 = 1, b0 = 1 (add) and a1 = 9, b1 = 4 (sub) → done0 at t+2 with res = 2; done1 at t+4 with res = 5.
- Fairness: both req held high for 12 cycles → 6 grants alternating 0,1,0,1,0,1; busy toggles 1,0 each cycle pair.
- Operand change after gnt: a0 is changed to 100 in the cycle after gnt0 → res still reflects the captured operands (5 + 3 = 8).
- Reset mid-op: RST_N pulled low during EXEC →
  - All outputs 0 immediately; no done pulse.
  - Next request completes normally 2 cycles after it is sampled.
